// File: rtl/pipelined_csa_acc.sv
// pipelined_csa_acc: framed signed accumulator that keeps a carry-save sum during
// the frame and resolves it with one carry-propagate add before presenting the result.
module pipelined_csa_acc #(
    parameter int IN_W      = 16,
    parameter int ACC_W     = 40,
    parameter int MAX_TERMS = 256,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);
    if (ACC_W < IN_W + $clog2(MAX_TERMS)) begin : g_bad_cfg
        $fatal(1, "ACC_W too narrow for IN_W and MAX_TERMS");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUT} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   sum_q, carry_q, sum_d, carry_d;
    logic [ACC_W-1:0]   x, c_sh, s_in, c_in;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trunc_q, trunc_d;
    logic               out_valid_q, out_trunc_q;
    logic [ACC_W-1:0]   out_data_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               first, accept, close;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

    // The first beat of a frame starts from a zero redundant pair.
    always_comb begin
        x       = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
        c_sh    = {carry_q[ACC_W-2:0], 1'b0};
        first   = state_q == IDLE;
        s_in    = first ? '0 : sum_q;
        c_in    = first ? '0 : c_sh;
        sum_d   = s_in ^ c_in ^ x;
        carry_d = (s_in & c_in) | (s_in & x) | (c_in & x);
        cnt_d   = (first ? '0 : cnt_q) + CNT_W'(1);
        close   = in_last || (cnt_d == CNT_W'(MAX_TERMS));
        trunc_d = (cnt_d == CNT_W'(MAX_TERMS)) && !in_last;
        accept  = in_valid && in_ready && !clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: if (accept) begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    trunc_q <= trunc_d;
                    state_q <= close ? RESOLVE : ACCUM;
                end
                RESOLVE: begin
                    out_data_q  <= sum_q + c_sh;
                    out_count_q <= cnt_q;
                    out_trunc_q <= trunc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                default: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipelined_csa_acc.sv
// tb_pipelined_csa_acc: vector table, hand sequences for reset/clr/truncation and
// random frames checked against an integer-sum reference model.
module tb_pipelined_csa_acc;
    localparam int IN_W = 16, ACC_W = 40, MAX_TERMS = 8, CNT_W = 4;

    logic             clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_ready, out_valid, out_trunc;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    int checks = 0, errors = 0;

    pipelined_csa_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int               n;
        logic [0:7][15:0] d;
        bit               last;
        int               hold;
        logic [ACC_W-1:0] exp_data;
        int               exp_cnt;
        bit               exp_trunc;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last, input int gap);
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk("in_ready_beat", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string nm, input int hold, input logic [ACC_W-1:0] ed,
                              input int ec, input bit et);
        int lat;
        lat = 1;
        chk({nm, "_resolve_ready"}, in_ready, 0);
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, lat, 2);
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_count"}, out_count, ec);
        chk({nm, "_trunc"}, out_trunc, et);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_ready"}, in_ready, 0);
            chk({nm, "_hold_data"}, out_data, ed);
            chk({nm, "_hold_count"}, out_count, ec);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, "_done_valid"}, out_valid, 0);
        chk({nm, "_done_ready"}, in_ready, 1);
    endtask

    task automatic run_frame(input string nm, input int n, input logic [0:7][15:0] d,
                             input bit last, input int hold, input logic [ACC_W-1:0] ed,
                             input int ec, input bit et, input int maxgap);
        for (int i = 0; i < n; i++)
            send_beat(d[i], last && (i == n - 1), (i == 0) ? 0 : $urandom_range(maxgap));
        get_result(nm, hold, ed, ec, et);
    endtask

    initial begin
        tbl[0] = '{4, {16'd1, 16'd2, 16'd3, 16'd4, 64'd0}, 1'b1, 0, 40'd10, 4, 1'b0};
        tbl[1] = '{4, {16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 64'd0}, 1'b1, 5,
                   40'hFFFFFEFFFF, 4, 1'b0};
        tbl[2] = '{1, {16'h7FFF, 112'd0}, 1'b1, 0, 40'd32767, 1, 1'b0};
        tbl[3] = '{8, {8{16'h7FFF}}, 1'b1, 1, 40'd262136, 8, 1'b0};
        tbl[4] = '{8, {8{16'h8000}}, 1'b0, 0, 40'hFFFFFC0000, 8, 1'b1};
        tbl[5] = '{3, {16'hFFFF, 16'h0001, 16'hFFFE, 80'd0}, 1'b1, 0, 40'hFFFFFFFFFE, 3, 1'b0};

        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_trunc", out_trunc, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", in_ready, 1);

        for (int t = 0; t < 6; t++)
            run_frame($sformatf("vec%0d", t), tbl[t].n, tbl[t].d, tbl[t].last, tbl[t].hold,
                      tbl[t].exp_data, tbl[t].exp_cnt, tbl[t].exp_trunc, 0);

        // nine beats of 1 without last: first frame closes at MAX_TERMS, beat 9 opens the next
        for (int i = 0; i < 8; i++) send_beat(16'd1, 1'b0, 0);
        get_result("trunc9", 0, 40'd8, 8, 1'b1);
        send_beat(16'd1, 1'b0, 0);
        send_beat(16'd5, 1'b1, 2);
        get_result("after_trunc", 0, 40'd6, 2, 1'b0);

        // async reset mid-frame discards the partial sum and the previous result
        send_beat(16'd9, 1'b0, 0);
        send_beat(16'd9, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_count", out_count, 0);
        chk("midrst_trunc", out_trunc, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_valid", out_valid, 0);
        end
        run_frame("after_rst", 1, {16'd3, 112'd0}, 1'b1, 0, 40'd3, 1, 1'b0, 0);

        // clr in ACCUM after three beats; the beat presented with clr is dropped
        for (int i = 0; i < 3; i++) send_beat(16'd100, 1'b0, 0);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd50;
        in_last = 1'b1;
        chk("clr_cycle_ready", in_ready, 1);
        step();
        clr = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("clr_idle_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("clr_no_valid", out_valid, 0);
        end
        run_frame("after_clr", 1, {16'd7, 112'd0}, 1'b1, 0, 40'd7, 1, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            logic [0:7][15:0] d;
            longint s;
            int n;
            bit last;
            n = $urandom_range(1, MAX_TERMS);
            last = (n < MAX_TERMS) ? 1'b1 : 1'($urandom_range(1));
            s = 0;
            d = '0;
            for (int i = 0; i < n; i++) begin
                d[i] = 16'($urandom);
                s += longint'($signed(d[i]));
            end
            run_frame($sformatf("rnd%0d", r), n, d, last, $urandom_range(2), s[ACC_W-1:0],
                      n, !last, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
